// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and constants for the UART frame parser
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

endpackage

// File: rtl/frame_payload_buf.sv
// rtl/frame_payload_buf.sv - payload register file, one write port, one registered read port
module frame_payload_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_d;
    logic [7:0] rd_data_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - hunts, collects and verifies HEADER/CMD/LEN/payload/CHK frames
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] HEADER         = DEFAULT_HEADER,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100_000,
    localparam int        AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          frame_valid,
    output logic [7:0]    frame_cmd,
    output logic [7:0]    frame_len,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_err,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state_q, state_d;
    logic [7:0]    sum_q, sum_d;
    logic [7:0]    cmd_sh_q, cmd_sh_d;
    logic [7:0]    len_sh_q, len_sh_d;
    logic [AW-1:0] wr_idx_q, wr_idx_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          frame_valid_q, frame_valid_d;
    logic [7:0]    frame_cmd_q, frame_cmd_d;
    logic [7:0]    frame_len_q, frame_len_d;
    logic          frame_err_q, frame_err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          buf_wr_en;
    logic          busy_w;

    assign busy_w = (state_q != ST_HUNT) && (state_q != ST_HOLD);

    always_comb begin
        state_d       = state_q;
        sum_d         = sum_q;
        cmd_sh_d      = cmd_sh_q;
        len_sh_d      = len_sh_q;
        wr_idx_d      = wr_idx_q;
        tmo_cnt_d     = tmo_cnt_q;
        frame_valid_d = frame_valid_q;
        frame_cmd_d   = frame_cmd_q;
        frame_len_d   = frame_len_q;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        buf_wr_en     = 1'b0;

        // A byte arriving on the timeout cycle clears the counter, so it always wins.
        if (in_valid || !busy_w) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_cnt_d   = '0;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
            state_d     = ST_HUNT;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        case (state_q)
            ST_HUNT: begin
                if (in_valid && in_data == HEADER) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (in_valid) begin
                    cmd_sh_d = in_data;
                    sum_d    = in_data;
                    state_d  = ST_LEN;
                end
            end
            ST_LEN: begin
                if (in_valid) begin
                    sum_d    = sum_q + in_data;
                    len_sh_d = in_data;
                    wr_idx_d = '0;
                    if (in_data > 8'(MAX_LEN)) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                        state_d     = ST_HUNT;
                    end else if (in_data == 8'h00) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (in_valid) begin
                    buf_wr_en = 1'b1;
                    sum_d     = sum_q + in_data;
                    wr_idx_d  = wr_idx_q + 1'b1;
                    if (wr_idx_q == AW'(len_sh_q - 8'd1)) begin
                        state_d = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (in_valid) begin
                    if (in_data == sum_q) begin
                        state_d       = ST_HOLD;
                        frame_valid_d = 1'b1;
                        frame_cmd_d   = cmd_sh_q;
                        frame_len_d   = len_sh_q;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CHK;
                        state_d     = ST_HUNT;
                    end
                end
            end
            ST_HOLD: begin
                if (frame_ack) begin
                    frame_valid_d = 1'b0;
                    state_d = (in_valid && in_data == HEADER) ? ST_CMD : ST_HUNT;
                end else if (in_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HUNT;
            sum_q         <= 8'h00;
            cmd_sh_q      <= 8'h00;
            len_sh_q      <= 8'h00;
            wr_idx_q      <= '0;
            tmo_cnt_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_cmd_q   <= 8'h00;
            frame_len_q   <= 8'h00;
            frame_err_q   <= 1'b0;
            err_code_q    <= 2'd0;
        end else begin
            state_q       <= state_d;
            sum_q         <= sum_d;
            cmd_sh_q      <= cmd_sh_d;
            len_sh_q      <= len_sh_d;
            wr_idx_q      <= wr_idx_d;
            tmo_cnt_q     <= tmo_cnt_d;
            frame_valid_q <= frame_valid_d;
            frame_cmd_q   <= frame_cmd_d;
            frame_len_q   <= frame_len_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
        end
    end

    frame_payload_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (buf_wr_en),
        .wr_addr (wr_idx_q),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign frame_valid = frame_valid_q;
    assign frame_cmd   = frame_cmd_q;
    assign frame_len   = frame_len_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign busy        = busy_w;

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Byte-level framing stage directly downstream of the UART receiver. It consumes the receiver's one-cycle `data`/`valid` byte strobes, hunts for a header byte, and collects the command, length, payload and checksum fields. It verifies each frame, then holds the accepted frame for the command/control logic until that logic acknowledges it. Framing, length, checksum, timeout and overrun faults are reported as single-cycle error pulses.

## Interface
Parameters:
- `HEADER`, 8'hAA: start-of-frame byte.
- `MAX_LEN`, 16: maximum payload bytes (1..255).
- `TIMEOUT_CYCLES`, 100_000: maximum idle clocks between bytes inside a frame (1 ms at 100 MHz).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `in_data` in 8: received byte from the UART receiver.
- `in_valid` in 1: one-cycle strobe, `in_data` valid. There is no backpressure.
- `frame_valid` out 1: level, high while an accepted frame is held.
- `frame_cmd` out 8: command byte of the held frame.
- `frame_len` out 8: payload length of the held frame.
- `frame_ack` in 1: one-cycle release of the held frame.
- `rd_addr` in `$clog2(MAX_LEN)`: payload read index.
- `rd_data` out 8: payload byte at `rd_addr`, registered.
- `frame_err` out 1: one-cycle error pulse.
- `err_code` out 2: valid with `frame_err`. 0 = overrun, 1 = checksum, 2 = length, 3 = timeout.
- `busy` out 1: high in any state other than HUNT and HOLD.

## Operation
- Frame format: HEADER, CMD, LEN, LEN payload bytes, CHK.
- CHK = (CMD + LEN + sum of payload) mod 256.
- States: HUNT, CMD, LEN, PAYLOAD, CHK, HOLD.
- HUNT: a byte equal to HEADER moves to CMD. All other bytes are discarded silently.
- CMD: latch the byte into `frame_cmd` shadow, initialise the sum to the byte, go to LEN.
- LEN: if the byte is greater than MAX_LEN, pulse error code 2 and go to HUNT. If the byte is 0, go to CHK. Otherwise clear the write index and go to PAYLOAD. Add the byte to the sum in every case.
- PAYLOAD: write the byte to the buffer at the write index and add it to the sum. After byte LEN-1, go to CHK.
- CHK: if the byte equals the sum, go to HOLD and assert `frame_valid`. Otherwise pulse error code 1 and go to HUNT.
- The sum is an 8-bit accumulator that wraps modulo 256.
- HOLD: `frame_cmd`, `frame_len` and the buffer are frozen.
  - `in_valid` without `frame_ack`: the byte is dropped and error code 0 pulses.
  - `frame_ack` alone: go to HUNT on the next cycle.
  - `frame_ack` and `in_valid` in the same cycle: no overrun. The byte is evaluated as in HUNT, so a HEADER byte goes straight to CMD.
- `frame_ack` outside HOLD is ignored.
- Timeout counter:
  - Cleared on every `in_valid`.
  - Counts only in CMD, LEN, PAYLOAD and CHK.
  - At TIMEOUT_CYCLES the parser pulses error code 3 and returns to HUNT.
  - If the timeout cycle coincides with `in_valid`, the byte wins and there is no timeout.
- A failed frame never alters `frame_cmd`, `frame_len` or `frame_valid`. Those outputs are updated only on entry to HOLD.
- Reset values:
  - State HUNT.
  - `frame_valid`, `frame_err`, `busy`: 0.
  - `err_code`, `frame_cmd`, `frame_len`, `rd_data`: 0.
  - Sum and counters: 0.
  - Buffer contents are not reset.
- Reset mid-frame discards the partial frame without raising an error.

## Timing
- Every `in_valid` is processed in the cycle it is asserted.
- `frame_valid` rises on the clock edge of the CHK byte, so it is seen one cycle after that strobe.
- `frame_err` and `err_code` are registered and appear one cycle after the causing byte or timeout cycle.
- `rd_data` has 1-cycle latency from `rd_addr`. It is readable in any state and is meaningful in HOLD for indices below `frame_len`.
- `frame_valid` falls one cycle after `frame_ack`.

## Structure
- Package `uart_frame_pkg`:
  - State enum.
  - Error-code constants (`ERR_OVERRUN`, `ERR_CHK`, `ERR_LEN`, `ERR_TIMEOUT`).
  - Default HEADER constant.
- Sub-module `frame_payload_buf`: simple-dual-port MAX_LEN x 8 register file. It has a write port and a registered read port, and the parser gates the write enable off in HOLD.

## Test plan
- AA 01 02 10 20 33 -> `frame_valid`=1, `frame_cmd`=01, `frame_len`=2, rd 0/1 = 10/20. No `frame_err`.
- AA 01 02 10 20 34 -> `frame_err` with code 1, `frame_valid` stays 0, parser back in HUNT. A following good frame is accepted.
- AA 05 11 (MAX_LEN=16) -> code 2. AA 07 00 07 -> accepted with `frame_len`=0.
- AA 01 then TIMEOUT_CYCLES quiet clocks -> code 3 exactly once, `busy`=0. Bytes 55 00 before an AA are ignored silently.
- Good frame held, then byte 12 without ack -> code 0, held outputs unchanged. Ack together with AA -> frame released and new frame parsing starts at CMD.
- Assert `rst_n` low mid-payload -> all outputs 0 asynchronously, no error pulse after release. Sum wrap: AA FF 01 02 02 -> accepted.
